// File: rtl/noc_packetizer.sv
// NoC packetizer: turns a packet request (destination + length) and a stream
// of payload words into a head/body/tail flit sequence. Flits go out through
// one output register that can be reloaded in the same cycle it drains, so a
// packet streams at one flit per cycle.
module noc_packetizer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [29:0] req_dest_x,
    input  logic [29:0] req_dest_y,
    input  logic [3:0]  req_len,
    input  logic        pay_valid,
    output logic        pay_ready,
    input  logic [63:0] pay_data,
    output logic        flit_valid,
    input  logic        flit_ready,
    output logic [63:0] flit_data,
    output logic [1:0]  flit_type,
    output logic        busy,
    output logic [15:0] pkt_count
);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    localparam logic [1:0] TYPE_HEAD      = 2'b00;
    localparam logic [1:0] TYPE_BODY      = 2'b01;
    localparam logic [1:0] TYPE_TAIL      = 2'b10;
    localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

    state_t     state_reg;
    logic [3:0] rem_reg;

    logic out_free;
    logic req_fire;
    logic pay_fire;
    logic flit_fire;

    // The output register can take a new flit if it is empty or draining now.
    assign out_free  = !flit_valid || flit_ready;
    assign req_ready = (state_reg == IDLE) && out_free;
    assign pay_ready = (state_reg == BODY) && out_free;
    assign req_fire  = req_valid && req_ready;
    assign pay_fire  = pay_valid && pay_ready;
    assign flit_fire = flit_valid && flit_ready;
    assign busy      = (state_reg == BODY) || flit_valid;

    // Packet FSM, output flit register and completed-packet counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            rem_reg    <= 4'd0;
            flit_valid <= 1'b0;
            flit_data  <= 64'd0;
            flit_type  <= TYPE_HEAD;
            pkt_count  <= 16'd0;
        end else begin
            // A packet completes when its tail (or single head+tail) flit is taken.
            if (flit_fire && flit_type[1]) begin
                pkt_count <= pkt_count + 16'd1;
            end

            if (req_fire) begin
                flit_valid <= 1'b1;
                flit_data  <= {4'b0000, req_dest_y, req_dest_x};
                if (req_len == 4'd0) begin
                    flit_type <= TYPE_HEAD_TAIL;
                end else begin
                    flit_type <= TYPE_HEAD;
                    rem_reg   <= req_len;
                    state_reg <= BODY;
                end
            end else if (pay_fire) begin
                flit_valid <= 1'b1;
                flit_data  <= pay_data;
                rem_reg    <= rem_reg - 4'd1;
                if (rem_reg == 4'd1) begin
                    flit_type <= TYPE_TAIL;
                    state_reg <= IDLE;
                end else begin
                    flit_type <= TYPE_BODY;
                end
            end else if (flit_fire) begin
                // Drained with nothing to replace it: register becomes empty.
                flit_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_noc_packetizer.sv
// Testbench for noc_packetizer: directed scenarios plus a randomized phase
// checked against a packet-level model (expected flit stream built from the
// generated packets: head word followed by the payload words in order).
module tb_noc_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [29:0] req_dest_x;
    logic [29:0] req_dest_y;
    logic [3:0]  req_len;
    logic        pay_valid;
    logic        pay_ready;
    logic [63:0] pay_data;
    logic        flit_valid;
    logic        flit_ready;
    logic [63:0] flit_data;
    logic [1:0]  flit_type;
    logic        busy;
    logic [15:0] pkt_count;

    int checks = 0;
    int errors = 0;

    noc_packetizer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dest_x (req_dest_x),
        .req_dest_y (req_dest_y),
        .req_len    (req_len),
        .pay_valid  (pay_valid),
        .pay_ready  (pay_ready),
        .pay_data   (pay_data),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .flit_data  (flit_data),
        .flit_type  (flit_type),
        .busy       (busy),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Random-phase reference: packets to offer, flat payload stream, expected flits.
    logic [29:0] q_x[$];
    logic [29:0] q_y[$];
    logic [3:0]  q_len[$];
    logic [63:0] q_pay[$];
    logic [63:0] q_fdata[$];
    logic [1:0]  q_ftype[$];

    initial begin
        logic [63:0] a_w, b_w, c_w, hd;
        logic [63:0] p[4];
        logic [29:0] x, y;
        logic [3:0]  l;
        logic [63:0] d;
        logic [63:0] prev_data;
        logic [1:0]  prev_type;
        logic        prev_stall;
        int exp_pkt, ri, pi, ei, cyc;

        rst = 1'b1; req_valid = 1'b0; req_dest_x = '0; req_dest_y = '0; req_len = '0;
        pay_valid = 1'b0; pay_data = '0; flit_ready = 1'b0;
        exp_pkt = 0;

        // ---- Reset state
        repeat (2) @(negedge clk);
        chk("rst_flit_valid", 64'(flit_valid), 64'd0);
        chk("rst_flit_data", flit_data, 64'd0);
        chk("rst_flit_type", 64'(flit_type), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_pay_ready", 64'(pay_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        rst = 1'b0;

        // ---- Zero-length packet
        @(negedge clk);
        req_valid = 1'b1; req_dest_x = 30'd5; req_dest_y = 30'd3; req_len = 4'd0; flit_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_dest_x = 30'h3FFF_FFFF; req_dest_y = 30'h2AAA_AAAA;
        chk("zl_valid", 64'(flit_valid), 64'd1);
        chk("zl_type", 64'(flit_type), 64'd3);
        chk("zl_data", flit_data, 64'h0000_0000_C000_0005);
        chk("zl_cnt_before", 64'(pkt_count), 64'd0);
        @(negedge clk);
        exp_pkt = 1;
        chk("zl_cnt_after", 64'(pkt_count), 64'(exp_pkt));
        chk("zl_drained", 64'(flit_valid), 64'd0);
        chk("zl_busy", 64'(busy), 64'd0);

        // ---- Back-to-back streaming, len=3
        a_w = {$urandom, $urandom}; b_w = {$urandom, $urandom}; c_w = {$urandom, $urandom};
        x = 30'($urandom); y = 30'($urandom);
        hd = {4'b0000, y, x};
        req_valid = 1'b1; req_dest_x = x; req_dest_y = y; req_len = 4'd3;
        pay_valid = 1'b1; pay_data = a_w;
        @(negedge clk);
        req_valid = 1'b0;
        chk("bb_head_type", 64'(flit_type), 64'd0);
        chk("bb_head_data", flit_data, hd);
        chk("bb_pay_ready", 64'(pay_ready), 64'd1);
        @(negedge clk);
        chk("bb_a_type", 64'(flit_type), 64'd1);
        chk("bb_a_data", flit_data, a_w);
        pay_data = b_w;
        @(negedge clk);
        chk("bb_b_type", 64'(flit_type), 64'd1);
        chk("bb_b_data", flit_data, b_w);
        pay_data = c_w;
        @(negedge clk);
        chk("bb_c_type", 64'(flit_type), 64'd2);
        chk("bb_c_data", flit_data, c_w);
        chk("bb_req_ready", 64'(req_ready), 64'd1);
        chk("bb_pay_ready_idle", 64'(pay_ready), 64'd0);
        pay_valid = 1'b0;
        @(negedge clk);
        exp_pkt++;
        chk("bb_cnt", 64'(pkt_count), 64'(exp_pkt));

        // ---- Backpressure during body, len=4
        for (int i = 0; i < 4; i++) p[i] = {$urandom, $urandom};
        x = 30'($urandom); y = 30'($urandom);
        req_valid = 1'b1; req_dest_x = x; req_dest_y = y; req_len = 4'd4;
        pay_valid = 1'b1; pay_data = p[0];
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_head_data", flit_data, {4'b0000, y, x});
        @(negedge clk);
        chk("bp_p0_data", flit_data, p[0]);
        pay_data = p[1]; flit_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_data", flit_data, p[0]);
            chk("bp_hold_type", 64'(flit_type), 64'd1);
            chk("bp_hold_valid", 64'(flit_valid), 64'd1);
            chk("bp_pay_ready", 64'(pay_ready), 64'd0);
        end
        flit_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("bp_resume_data", flit_data, p[i]);
            chk("bp_resume_type", 64'(flit_type), (i == 3) ? 64'd2 : 64'd1);
            if (i < 3) pay_data = p[i+1];
        end
        pay_valid = 1'b0;
        @(negedge clk);
        exp_pkt++;
        chk("bp_cnt", 64'(pkt_count), 64'(exp_pkt));

        // ---- Payload starvation mid-packet, len=2, with a competing request
        p[0] = {$urandom, $urandom}; p[1] = {$urandom, $urandom};
        req_valid = 1'b1; req_dest_x = 30'($urandom); req_dest_y = 30'($urandom); req_len = 4'd2;
        @(negedge clk);
        chk("st_head_type", 64'(flit_type), 64'd0);
        req_len = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("st_valid_low", 64'(flit_valid), 64'd0);
            chk("st_busy", 64'(busy), 64'd1);
            chk("st_req_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0; pay_valid = 1'b1; pay_data = p[0];
        @(negedge clk);
        chk("st_p0_data", flit_data, p[0]);
        chk("st_p0_type", 64'(flit_type), 64'd1);
        pay_data = p[1];
        @(negedge clk);
        chk("st_p1_data", flit_data, p[1]);
        chk("st_p1_type", 64'(flit_type), 64'd2);
        pay_valid = 1'b0;
        @(negedge clk);
        exp_pkt++;
        chk("st_cnt", 64'(pkt_count), 64'(exp_pkt));

        // ---- Randomized phase against the packet-level model
        for (int k = 0; k < 40; k++) begin
            x = 30'($urandom); y = 30'($urandom); l = 4'($urandom_range(0, 15));
            q_x.push_back(x); q_y.push_back(y); q_len.push_back(l);
            q_fdata.push_back({4'b0000, y, x});
            q_ftype.push_back((l == 4'd0) ? 2'b11 : 2'b00);
            for (int i = 0; i < int'(l); i++) begin
                d = {$urandom, $urandom};
                q_pay.push_back(d);
                q_fdata.push_back(d);
                q_ftype.push_back((i == int'(l) - 1) ? 2'b10 : 2'b01);
            end
        end
        ri = 0; pi = 0; ei = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; prev_type = '0;
        while (ei < q_fdata.size() && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            chk("rnd_pkt_count", 64'(pkt_count), 64'(exp_pkt[15:0]));
            if (prev_stall) begin
                chk("rnd_hold_valid", 64'(flit_valid), 64'd1);
                chk("rnd_hold_data", flit_data, prev_data);
                chk("rnd_hold_type", 64'(flit_type), 64'(prev_type));
            end
            req_valid  = (ri < q_x.size()) && ($urandom_range(0, 3) != 0);
            req_dest_x = (ri < q_x.size()) ? q_x[ri] : 30'($urandom);
            req_dest_y = (ri < q_y.size()) ? q_y[ri] : 30'($urandom);
            req_len    = (ri < q_len.size()) ? q_len[ri] : 4'($urandom);
            pay_valid  = (pi < q_pay.size()) && ($urandom_range(0, 3) != 0);
            pay_data   = (pi < q_pay.size()) ? q_pay[pi] : {$urandom, $urandom};
            flit_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (req_valid && req_ready) ri++;
            if (pay_valid && pay_ready) pi++;
            if (flit_valid && flit_ready) begin
                chk("rnd_flit_data", flit_data, q_fdata[ei]);
                chk("rnd_flit_type", 64'(flit_type), 64'(q_ftype[ei]));
                if (q_ftype[ei][1]) exp_pkt++;
                ei++;
            end
            prev_stall = flit_valid && !flit_ready;
            prev_data  = flit_data;
            prev_type  = flit_type;
        end
        chk("rnd_all_flits", 64'(ei), 64'(q_fdata.size()));
        req_valid = 1'b0; pay_valid = 1'b0; flit_ready = 1'b1;
        @(negedge clk);
        chk("rnd_final_cnt", 64'(pkt_count), 64'(exp_pkt[15:0]));
        chk("rnd_idle", 64'(busy), 64'd0);

        // ---- Counter wrap: 65536 zero-length packets from a clean reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b1; req_len = 4'd0; flit_ready = 1'b1;
        repeat (65536) @(negedge clk);
        chk("wrap_cnt_ffff", 64'(pkt_count), 64'hFFFF);
        req_valid = 1'b0;
        @(negedge clk);
        chk("wrap_cnt_zero", 64'(pkt_count), 64'd0);
        chk("wrap_drained", 64'(flit_valid), 64'd0);

        // ---- Reset mid-packet
        p[0] = {$urandom, $urandom};
        req_valid = 1'b1; req_dest_x = 30'($urandom); req_dest_y = 30'($urandom); req_len = 4'd4;
        pay_valid = 1'b1; pay_data = p[0];
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mr_body_loaded", flit_data, p[0]);
        #2 rst = 1'b1;
        #1;
        chk("mr_async_valid", 64'(flit_valid), 64'd0);
        chk("mr_async_busy", 64'(busy), 64'd0);
        chk("mr_async_pay_ready", 64'(pay_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0; pay_valid = 1'b0;
        x = 30'($urandom); y = 30'($urandom); p[1] = {$urandom, $urandom};
        req_valid = 1'b1; req_dest_x = x; req_dest_y = y; req_len = 4'd1;
        @(negedge clk);
        chk("mr_head_type", 64'(flit_type), 64'd0);
        chk("mr_head_data", flit_data, {4'b0000, y, x});
        req_valid = 1'b0; pay_valid = 1'b1; pay_data = p[1];
        @(negedge clk);
        chk("mr_tail_type", 64'(flit_type), 64'd2);
        chk("mr_tail_data", flit_data, p[1]);
        pay_valid = 1'b0;
        @(negedge clk);
        chk("mr_cnt", 64'(pkt_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
